// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor. One segment carry is resolved per stage,
// with a single global advance enable driven by the output handshake.
module pipelined_csel_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned N = WIDTH / SEG;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [SEG:0]     seg0_t;

    // Values entering the final (stage N) register
    logic [WIDTH-1:0] fin_sum;
    logic             fin_cy;
    logic             fin_am;
    logic             fin_bm;
    logic             fin_v;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        b_eff   = sub ? ~b : b;
        cin_eff = sub | c_in;
        seg0_t  = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, cin_eff};
    end

    generate
        if (N == 1) begin : g_single
            always_comb begin
                fin_sum = WIDTH'(seg0_t[SEG-1:0]);
                fin_cy  = seg0_t[SEG];
                fin_am  = a[WIDTH-1];
                fin_bm  = b_eff[WIDTH-1];
                fin_v   = in_valid;
            end
        end else begin : g_pipe
            localparam int unsigned M = N - 1;

            logic [WIDTH-1:0]     pre_sum;
            logic [WIDTH-SEG-1:0] pre_alt;
            logic [M-1:0]         pre_co0;
            logic [M-1:0]         pre_co1;
            logic [SEG:0]         t0;
            logic [SEG:0]         t1;

            // st_sum: resolved low segments plus carry-in-0 candidates above them.
            // st_alt: carry-in-1 candidates for segments 1..N-1 (segment k at slot k-1).
            logic [WIDTH-1:0]     st_sum  [1:M];
            logic [WIDTH-SEG-1:0] st_alt  [1:M];
            logic [M-1:0]         st_co0  [1:M];
            logic [M-1:0]         st_co1  [1:M];
            logic [M:1]           st_cy;
            logic [M:1]           st_am;
            logic [M:1]           st_bm;
            logic [M:1]           st_v;

            logic [WIDTH-1:0]     nxt_sum [1:M];
            logic [WIDTH-SEG-1:0] nxt_alt [1:M];
            logic [M-1:0]         nxt_co0 [1:M];
            logic [M-1:0]         nxt_co1 [1:M];
            logic [M:1]           nxt_cy;
            logic [M:1]           nxt_am;
            logic [M:1]           nxt_bm;
            logic [M:1]           nxt_v;

            always_comb begin
                pre_sum = '0;
                pre_alt = '0;
                pre_co0 = '0;
                pre_co1 = '0;
                t0      = '0;
                t1      = '0;
                pre_sum[SEG-1:0] = seg0_t[SEG-1:0];
                for (int unsigned k = 1; k < N; k++) begin
                    t0 = {1'b0, a[k*SEG +: SEG]} + {1'b0, b_eff[k*SEG +: SEG]};
                    t1 = {1'b0, a[k*SEG +: SEG]} + {1'b0, b_eff[k*SEG +: SEG]} + {{SEG{1'b0}}, 1'b1};
                    pre_sum[k*SEG +: SEG]     = t0[SEG-1:0];
                    pre_co0[k-1]              = t0[SEG];
                    pre_alt[(k-1)*SEG +: SEG] = t1[SEG-1:0];
                    pre_co1[k-1]              = t1[SEG];
                end
            end

            always_comb begin
                nxt_sum[1] = pre_sum;
                nxt_alt[1] = pre_alt;
                nxt_co0[1] = pre_co0;
                nxt_co1[1] = pre_co1;
                nxt_cy[1]  = seg0_t[SEG];
                nxt_am[1]  = a[WIDTH-1];
                nxt_bm[1]  = b_eff[WIDTH-1];
                nxt_v[1]   = in_valid;
                for (int unsigned j = 2; j <= M; j++) begin
                    nxt_sum[j] = st_sum[j-1];
                    if (st_cy[j-1])
                        nxt_sum[j][(j-1)*SEG +: SEG] = st_alt[j-1][(j-2)*SEG +: SEG];
                    nxt_cy[j]  = st_cy[j-1] ? st_co1[j-1][j-2] : st_co0[j-1][j-2];
                    nxt_alt[j] = st_alt[j-1];
                    nxt_co0[j] = st_co0[j-1];
                    nxt_co1[j] = st_co1[j-1];
                    nxt_am[j]  = st_am[j-1];
                    nxt_bm[j]  = st_bm[j-1];
                    nxt_v[j]   = st_v[j-1];
                end
                fin_sum = st_sum[M];
                if (st_cy[M])
                    fin_sum[M*SEG +: SEG] = st_alt[M][(M-1)*SEG +: SEG];
                fin_cy = st_cy[M] ? st_co1[M][M-1] : st_co0[M][M-1];
                fin_am = st_am[M];
                fin_bm = st_bm[M];
                fin_v  = st_v[M];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_cy <= '0;
                    st_am <= '0;
                    st_bm <= '0;
                    st_v  <= '0;
                    for (int unsigned j = 1; j <= M; j++) begin
                        st_sum[j] <= '0;
                        st_alt[j] <= '0;
                        st_co0[j] <= '0;
                        st_co1[j] <= '0;
                    end
                end else if (adv) begin
                    st_cy <= nxt_cy;
                    st_am <= nxt_am;
                    st_bm <= nxt_bm;
                    st_v  <= nxt_v;
                    for (int unsigned j = 1; j <= M; j++) begin
                        st_sum[j] <= nxt_sum[j];
                        st_alt[j] <= nxt_alt[j];
                        st_co0[j] <= nxt_co0[j];
                        st_co1[j] <= nxt_co1[j];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= fin_v;
            sum       <= fin_sum;
            c_out     <= fin_cy;
            ovf       <= (fin_am == fin_bm) && (fin_sum[WIDTH-1] != fin_am);
            zero      <= (fin_sum == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder: directed vectors, random streams,
// backpressure, mid-stream reset and a parameter sweep against a signed/unsigned model.
module tb_pipelined_csel_adder;
    localparam int unsigned W = 64;
    localparam int unsigned S = 16;
    localparam int unsigned N = W / S;

    typedef struct packed {
        logic [63:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sb;
        logic        ci;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf, zero;
    logic [W-1:0] a, b, sum;

    pipelined_csel_adder #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    // Parameter sweep instances: 0 = 32/8, 1 = 16/16, 2 = 64/4
    logic [63:0] sw_a [3];
    logic [63:0] sw_b [3];
    logic        sw_sub, sw_ci;
    logic [2:0]  sw_iv, sw_ir, sw_ov, sw_co, sw_ovf, sw_z;
    logic [31:0] s32_sum;
    logic [15:0] s16_sum;
    logic [63:0] s64_sum;
    int unsigned sw_w   [3] = '{32, 16, 64};
    int unsigned sw_lat [3] = '{4, 1, 16};

    pipelined_csel_adder #(.WIDTH(32), .SEG(8)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]),
        .a(sw_a[0][31:0]), .b(sw_b[0][31:0]), .c_in(sw_ci), .sub(sw_sub),
        .out_valid(sw_ov[0]), .out_ready(1'b1), .sum(s32_sum),
        .c_out(sw_co[0]), .ovf(sw_ovf[0]), .zero(sw_z[0])
    );
    pipelined_csel_adder #(.WIDTH(16), .SEG(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]),
        .a(sw_a[1][15:0]), .b(sw_b[1][15:0]), .c_in(sw_ci), .sub(sw_sub),
        .out_valid(sw_ov[1]), .out_ready(1'b1), .sum(s16_sum),
        .c_out(sw_co[1]), .ovf(sw_ovf[1]), .zero(sw_z[1])
    );
    pipelined_csel_adder #(.WIDTH(64), .SEG(4)) u_w64s (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]),
        .a(sw_a[2]), .b(sw_b[2]), .c_in(sw_ci), .sub(sw_sub),
        .out_valid(sw_ov[2]), .out_ready(1'b1), .sum(s64_sum),
        .c_out(sw_co[2]), .ovf(sw_ovf[2]), .zero(sw_z[2])
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_pop  = 0;
    bit          lat_chk = 1'b0;
    bit          bp_on   = 1'b0;

    res_t        q  [$];
    int unsigned qc [$];
    bit          ql [$];

    res_t        swq [3][64];
    int unsigned swc [3][64];
    int unsigned swp [3];
    int unsigned swr [3];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: plain unsigned/signed arithmetic on w-bit operands
    function automatic res_t model(int unsigned w, logic [63:0] av, logic [63:0] bv,
                                   logic sb, logic ci);
        res_t               r;
        logic [63:0]        mask;
        logic [66:0]        ua, ub, ur;
        logic signed [66:0] sa, sbv, rs, lo, hi;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        av   = av & mask;
        bv   = bv & mask;
        ua   = {3'b000, av};
        ub   = {3'b000, bv};
        sa   = $signed(ua);
        sbv  = $signed(ub);
        if (av[w-1]) sa  = sa  - (67'sd1 <<< w);
        if (bv[w-1]) sbv = sbv - (67'sd1 <<< w);
        lo = -(67'sd1 <<< (w - 1));
        hi = (67'sd1 <<< (w - 1)) - 67'sd1;
        if (sb) begin
            ur      = ua - ub;
            rs      = sa - sbv;
            r.c_out = (av >= bv);
        end else begin
            ur      = ua + ub + {66'd0, ci};
            rs      = sa + sbv + $signed({66'd0, ci});
            r.c_out = (ur >= (67'd1 << w));
        end
        r.sum  = ur[63:0] & mask;
        r.ovf  = (rs < lo) || (rs > hi);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic logic [63:0] bnd(int unsigned w, int unsigned idx);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        case (idx)
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return m;
            default: return 64'd1 << (w - 1);
        endcase
    endfunction

    // Main-instance monitor: scoreboard, handshake rule, stall stability, reset values
    initial begin : mon
        int unsigned cyc, c0;
        bit          l, ps;
        res_t        e, pv;
        cyc = 0;
        ps  = 1'b0;
        pv  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_sum", sum, 0);
                chk("rst_flags", {c_out, ovf, zero}, 0);
                chk("rst_in_ready", in_ready, 1);
                q.delete();
                qc.delete();
                ql.delete();
                ps = 1'b0;
            end else begin
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
                chk("no_stale", out_valid && (q.size() == 0), 0);
                if (ps) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_sum", sum, pv.sum);
                    chk("stall_flags", {c_out, ovf, zero}, {pv.c_out, pv.ovf, pv.zero});
                end
                if (out_valid && out_ready && q.size() != 0) begin
                    e  = q.pop_front();
                    c0 = qc.pop_front();
                    l  = ql.pop_front();
                    chk("sum", sum, e.sum);
                    chk("c_out", c_out, e.c_out);
                    chk("ovf", ovf, e.ovf);
                    chk("zero", zero, e.zero);
                    if (l) chk("latency", cyc - c0, N);
                    n_pop++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(W, a, b, sub, c_in));
                    qc.push_back(cyc);
                    ql.push_back(lat_chk);
                end
                ps       = out_valid && !out_ready;
                pv.sum   = sum;
                pv.c_out = c_out;
                pv.ovf   = ovf;
                pv.zero  = zero;
            end
        end
    end

    // Sweep-instance monitor
    initial begin : sw_mon
        int unsigned cyc;
        logic [63:0] got;
        res_t        e;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    swp[i] = 0;
                    swr[i] = 0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    got = (i == 0) ? {32'd0, s32_sum} : (i == 1) ? {48'd0, s16_sum} : s64_sum;
                    if (sw_ov[i]) begin
                        if (swr[i] == swp[i]) begin
                            chk($sformatf("w%0d_spurious", sw_w[i]), 1, 0);
                        end else begin
                            e = swq[i][swr[i] % 64];
                            chk($sformatf("w%0d_sum", sw_w[i]), got, e.sum);
                            chk($sformatf("w%0d_flags", sw_w[i]), {sw_co[i], sw_ovf[i], sw_z[i]},
                                {e.c_out, e.ovf, e.zero});
                            chk($sformatf("w%0d_latency", sw_w[i]), cyc - swc[i][swr[i] % 64], sw_lat[i]);
                            swr[i]++;
                        end
                    end
                    if (sw_iv[i] && sw_ir[i]) begin
                        swq[i][swp[i] % 64] = model(sw_w[i], sw_a[i], sw_b[i], sw_sub, sw_ci);
                        swc[i][swp[i] % 64] = cyc;
                        swp[i]++;
                    end
                end
            end
        end
    end

    initial begin : bp_gen
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) out_ready = ($urandom_range(0, 99) < 30);
        end
    end

    task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic sb, input logic ci);
        int unsigned t;
        t        = 0;
        a        = av;
        b        = bv;
        sub      = sb;
        c_in     = ci;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned t;
        t = 0;
        while (q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_drained"}, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : drv
        vec_t        dv [7];
        res_t        r;
        int unsigned p0;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
        sw_sub = 1'b0; sw_ci = 1'b0; sw_iv = '0;
        for (int i = 0; i < 3; i++) begin
            sw_a[i] = '0;
            sw_b[i] = '0;
        end

        dv[0] = '{64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        dv[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
        dv[2] = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        dv[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        dv[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        dv[5] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
        dv[6] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors; each literal also pins the model
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            r = model(64, dv[i].a, dv[i].b, dv[i].sb, dv[i].ci);
            chk($sformatf("pin%0d_sum", i), r.sum, dv[i].s);
            chk($sformatf("pin%0d_flags", i), {r.c_out, r.ovf, r.zero}, {dv[i].co, dv[i].ov, dv[i].z});
            send(dv[i].a, dv[i].b, dv[i].sb, dv[i].ci);
        end
        drain("directed");

        // Back-to-back stream
        p0 = n_pop;
        for (int i = 0; i < 100; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (N) @(negedge clk);
        #1;
        chk("b2b_count", n_pop - p0, 100);
        drain("b2b");
        lat_chk = 1'b0;

        // Mid-stream reset discards in-flight operations
        for (int i = 0; i < 3; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = n_pop;
        repeat (N + 4) @(posedge clk);
        #1;
        chk("stale_pops", n_pop - p0, 0);

        // Backpressure with random gaps
        bp_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                @(posedge clk);
                #1;
            end
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        bp_on = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("backpressure");

        // Parameter sweep over boundary operands
        for (int unsigned ai = 0; ai < 4; ai++)
            for (int unsigned bi = 0; bi < 4; bi++)
                for (int unsigned s = 0; s < 2; s++) begin
                    for (int i = 0; i < 3; i++) begin
                        sw_a[i] = bnd(sw_w[i], ai);
                        sw_b[i] = bnd(sw_w[i], bi);
                    end
                    sw_sub = (s == 1);
                    sw_ci  = (s == 0) && (((ai + bi) % 2) == 1);
                    sw_iv  = '1;
                    @(posedge clk);
                    #1;
                end
        sw_iv = '0;
        repeat (30) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w%0d_accepted", sw_w[i]), swp[i], 32);
            chk($sformatf("w%0d_delivered", sw_w[i]), swr[i], 32);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_csel_adder.md
# pipelined_csel_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake. The operand is split into equal segments. Each segment precomputes its carry-in-0 and carry-in-1 sums. Each pipeline stage resolves the true carry for one segment and selects the matching sum. The block replaces fixed-width combinational carry-select adders where a datapath needs configurable width, subtraction, status flags and one result per cycle at a short critical path.

## Interface
- WIDTH, 64: operand and result width in bits. Must be a multiple of SEG.
- SEG, 16: segment width in bits. N = WIDTH/SEG is the number of pipeline stages. N = 1 is legal.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in. Used only when sub=0.
- sub  in  1  1 = compute a - b, 0 = compute a + b + c_in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB. When sub=1, 1 means no borrow (a >= b unsigned).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Accept: a transfer occurs when in_valid && in_ready.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in.
- Before the stage-1 register, segment 0 is computed with cin_eff. Segments 1..N-1 each compute a candidate pair {sum0, co0} (carry-in 0) and {sum1, co1} (carry-in 1) from a and b_eff.
- Stage k (k = 1..N-1) uses the carry resolved in stage k-1 to select segment k's candidate. It registers the selected SEG bits and the resolved carry. Candidates for unresolved segments pass forward unchanged.
- Stage N holds the full sum and the final carry, which drives c_out.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). The operand MSBs are carried down the pipe for this.
- zero is computed from the final sum in stage N.
- Each stage has one valid bit. Stage k's registers hold the operation accepted k cycles earlier, absent stalls.
- Global advance enable: adv = !out_valid || out_ready.
  - adv = 1: every stage shifts forward, valid bits included.
  - adv = 0: every stage holds.
- in_ready = adv, a combinational function of out_valid and out_ready.
- Bubbles: an empty stage still shifts when adv = 1. The pipeline does not compress bubbles while stalled.
- out_valid is the stage-N valid bit. sum, c_out, ovf and zero are the stage-N registers.
- Arithmetic is modulo 2^WIDTH. Carry/borrow is reported only via c_out.

## Timing
- Latency: N cycles from the accepting edge to out_valid, with no stall. WIDTH=64, SEG=16 gives 4 cycles.
- Throughput: one operation per cycle while out_ready is held high.
- Stall: with out_valid=1 and out_ready=0:
  - all outputs hold stable;
  - in_ready = 0;
  - no operand is lost or duplicated.
- When out_ready rises during a stall, the held result transfers on that edge. The pipeline advances on the same edge.
- Reset (asynchronous assert, rst_n low): all valid bits go to 0, and out_valid, sum, c_out, ovf go to 0. zero resets to 0. in_ready reads 1 while in reset.
- Reset mid-operation discards all in-flight operations. No result for them is ever presented.
- After reset deassertion, the first accept can occur on the first rising clock edge.
- Critical path: one SEG-bit ripple plus one 2:1 mux level per stage, independent of WIDTH.

## Test plan
- Reset and flags, WIDTH=64, SEG=16:
  - Drive rst_n=0 mid-stream → out_valid=0, sum=0, in_ready=1. No stale result appears after release.
  - a=0, b=0, sub=0, c_in=0 → sum=0, zero=1, c_out=0.
- Carry chain across all segments: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1, sub=0 → sum=0, c_out=1, zero=1, ovf=0. Result appears exactly 4 cycles after the accept.
- Subtract and overflow:
  - a=5, b=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0.
  - a=64'h8000_0000_0000_0000, b=1, sub=1 → sum=64'h7FFF_FFFF_FFFF_FFFF, c_out=1, ovf=1.
- Back-to-back: 100 random operations, in_valid and out_ready held high → one result per cycle, in order, each matching the reference model.
- Backpressure: random out_ready duty (30%), random in_valid → outputs stable while stalled, no loss or duplication, in-order results, and in_ready == (!out_valid || out_ready) every cycle.
- Parameter sweep: {WIDTH=32, SEG=8} (latency 4), {WIDTH=16, SEG=16} (latency 1), {WIDTH=64, SEG=4} (latency 16). Exhaustive boundary operands (0, 1, all-ones, MSB-only) for add and sub, checked against the reference model.
